unified_mem_arbiter: RTL and testbench
======================================

// Module: unified_mem_arbiter
// PURPOSE
//  Shares one single-port, fixed-latency unified memory between the instruction fetch
//  path (IF port) and the load/store path (D port) of the RV32I core.
//  - Request/grant handshake on each port; data port has priority over fetch.
//  - Sequences each access as a MEM_LAT-cycle memory transaction and returns a one-cycle
//    rvalid pulse to the winning requester.
//  - Exported busy signal lets the core stall the PC while an access is in flight.
// PARAMETERS
//  ADDR_W      32  address width, both ports and memory
//  DATA_W      32  data width
//  MEM_LAT      2  cycles the memory needs per access (>=1)
//  STARVE_MAX   4  consecutive D grants with IF waiting before IF is forced (guard only)
// PORTS
//  clk        in   1       clock, rising edge
//  n_rst      in   1       asynchronous active-low reset
//  if_req     in   1       fetch request; held until if_gnt
//  if_addr    in   ADDR_W  fetch address; stable while if_req=1
//  if_gnt     out  1       fetch granted (combinational, IDLE only)
//  if_rvalid  out  1       one-cycle pulse: if_rdata valid
//  if_rdata   out  DATA_W  fetched instruction
//  d_req      in   1       load/store request; held until d_gnt
//  d_we       in   1       1=store, 0=load
//  d_addr     in   ADDR_W  data address
//  d_wdata    in   DATA_W  store data
//  d_gnt      out  1       data granted (combinational, IDLE only)
//  d_rvalid   out  1       one-cycle pulse: load data valid / store complete
//  d_rdata    out  DATA_W  load data
//  mem_en     out  1       memory access active
//  mem_we     out  1       memory write enable
//  mem_addr   out  ADDR_W  memory address (registered)
//  mem_wdata  out  DATA_W  memory write data (registered)
//  mem_rdata  in   DATA_W  memory read data, valid in last cycle of access
//  busy       out  1       state != IDLE
// BEHAVIOUR
//  - Reset: state=IDLE; all outputs 0; latched addr/we/wdata, lat counter, starve counter = 0.
//  - States: IDLE, ACC_IF, ACC_D.
//  - IDLE, cycle T: d_req -> d_gnt=1, latch d_addr/d_we/d_wdata, next ACC_D.
//    Else if_req -> if_gnt=1, latch if_addr (we=0, wdata=0), next ACC_IF. Else stay.
//    At most one gnt per cycle; gnt never asserted outside IDLE.
//  - ACC_x, cycles T+1..T+MEM_LAT: mem_en=1; mem_we/addr/wdata from latches, stable;
//    lat counter counts 1..MEM_LAT.
//  - Cycle T+MEM_LAT: owner's rvalid=1; owner's rdata=mem_rdata (pass-through);
//    next IDLE. Stores also pulse d_rvalid (rdata don't-care).
//  - Non-owner rvalid=0, rdata=0 at all times.
//  - Next grant earliest at T+MEM_LAT+1: one access per MEM_LAT+1 cycles; gnt->rvalid = MEM_LAT.
//  - Requester may drop/change req and addr the cycle after gnt; the arbiter never re-samples.
//  - Simultaneous if_req & d_req in IDLE: D wins (subject to guard below); IF waits with
//    if_req high.
//  - Counter widths: lat counter clog2(MEM_LAT+1); starve counter clog2(STARVE_MAX+1), saturating.
//  - Reset mid-access: immediate return to IDLE; no rvalid for the aborted access;
//    mem_en drops asynchronously.
// CONFIGURATION
//  STARVE_GUARD_EN defined:
//  - Starve counter +1 on every D grant made while if_req=1.
//  - Counter clears on any IF grant, or when a D grant occurs with if_req=0.
//  - When counter==STARVE_MAX and both request in IDLE, IF wins; counter clears.
//  STARVE_GUARD_EN undefined: strict D>IF priority; no starve counter (IF may starve indefinitely).
// TESTING (MEM_LAT=2, STARVE_MAX=4)
//  1 Reset: n_rst=0 mid-ACC_D -> busy=0, mem_en=0, all gnt/rvalid=0, no d_rvalid after release.
//  2 Lone fetch: if_req, if_addr=0x10 at T, mem_rdata=0x00500093 ->
//    if_gnt@T; mem_en,mem_addr=0x10 @T+1..T+2; if_rvalid,if_rdata=0x00500093 @T+2; busy=0 @T+3.
//  3 Store: d_req, d_we=1, d_addr=0x40, d_wdata=0xDEADBEEF at T ->
//    mem_we=1, mem_wdata=0xDEADBEEF @T+1..T+2; d_rvalid @T+2; if_rvalid stays 0.
//  4 Collision: if_req & d_req (load 0x44) at T ->
//    d_gnt@T, d_rvalid@T+2; if_gnt@T+3, if_rvalid@T+5.
//  5 Starvation, guard on: if_req held, d_req held continuously ->
//    4 D grants, then IF grant on the 5th slot, then D resumes.
//    Guard off: IF never granted while d_req=1.
//  6 Back-to-back: req held high continuously -> grants exactly every 3 cycles;
//    never two grants or two rvalids in one cycle.

Source files
------------

// File: rtl/unified_mem_arbiter.sv
// Arbitrates one single-port fixed-latency memory between instruction fetch (IF) and load/store (D).
// Optional IF anti-starvation guard: define STARVE_GUARD_EN.
module unified_mem_arbiter #(
    parameter int ADDR_W     = 32,
    parameter int DATA_W     = 32,
    parameter int MEM_LAT    = 2,
    parameter int STARVE_MAX = 4
) (
    input  logic              clk,
    input  logic              n_rst,
    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    output logic              if_gnt,
    output logic              if_rvalid,
    output logic [DATA_W-1:0] if_rdata,
    input  logic              d_req,
    input  logic              d_we,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [DATA_W-1:0] d_wdata,
    output logic              d_gnt,
    output logic              d_rvalid,
    output logic [DATA_W-1:0] d_rdata,
    output logic              mem_en,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              busy,
    output logic [1:0]        dbg_state
);

    // Handshake: a requester holds req (and its address/data) until it sees gnt in the
    // same cycle; gnt only appears in IDLE and the request fields are latched on that edge.
    // The owner's rvalid pulses exactly MEM_LAT cycles later.
    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACC_IF = 2'd1,
        ACC_D  = 2'd2
    } state_t;

    localparam int LAT_W = $clog2(MEM_LAT + 1);
    localparam logic [LAT_W-1:0] LAT_LAST = LAT_W'(MEM_LAT);

    state_t            state_q;
    logic [LAT_W-1:0]  lat_q;
    logic              mem_en_q;
    logic              mem_we_q;
    logic [ADDR_W-1:0] mem_addr_q;
    logic [DATA_W-1:0] mem_wdata_q;
    logic              force_if;
    logic              in_idle;
    logic              last_cyc;

`ifdef STARVE_GUARD_EN
    localparam int SW = $clog2(STARVE_MAX + 1);
    localparam logic [SW-1:0] STARVE_TOP = SW'(STARVE_MAX);

    logic [SW-1:0] starve_q;
    logic [SW-1:0] starve_d;

    assign force_if = (starve_q == STARVE_TOP) && if_req && d_req;

    // Counts D wins that left a fetch waiting; saturates so it only ever forces one IF slot.
    always_comb begin
        starve_d = starve_q;
        if (d_gnt) begin
            if (!if_req)
                starve_d = '0;
            else if (starve_q != STARVE_TOP)
                starve_d = starve_q + SW'(1);
        end else if (if_gnt) begin
            starve_d = '0;
        end
    end

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst)
            starve_q <= '0;
        else
            starve_q <= starve_d;
    end
`else
    assign force_if = 1'b0;
`endif

    assign in_idle  = (state_q == IDLE);
    assign d_gnt    = in_idle && d_req && !force_if;
    assign if_gnt   = in_idle && if_req && !d_gnt;
    assign last_cyc = !in_idle && (lat_q == LAT_LAST);

    assign if_rvalid = last_cyc && (state_q == ACC_IF);
    assign d_rvalid  = last_cyc && (state_q == ACC_D);
    assign if_rdata  = if_rvalid ? mem_rdata : '0;
    assign d_rdata   = d_rvalid ? mem_rdata : '0;

    assign mem_en    = mem_en_q;
    assign mem_we    = mem_we_q;
    assign mem_addr  = mem_addr_q;
    assign mem_wdata = mem_wdata_q;
    assign busy      = !in_idle;
    assign dbg_state = state_q;

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state_q     <= IDLE;
            lat_q       <= '0;
            mem_en_q    <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (d_gnt) begin
                        state_q     <= ACC_D;
                        lat_q       <= LAT_W'(1);
                        mem_en_q    <= 1'b1;
                        mem_we_q    <= d_we;
                        mem_addr_q  <= d_addr;
                        mem_wdata_q <= d_wdata;
                    end else if (if_gnt) begin
                        state_q     <= ACC_IF;
                        lat_q       <= LAT_W'(1);
                        mem_en_q    <= 1'b1;
                        mem_we_q    <= 1'b0;
                        mem_addr_q  <= if_addr;
                        mem_wdata_q <= '0;
                    end
                end
                default: begin
                    if (lat_q == LAT_LAST) begin
                        state_q  <= IDLE;
                        lat_q    <= '0;
                        mem_en_q <= 1'b0;
                        mem_we_q <= 1'b0;
                    end else begin
                        lat_q <= lat_q + LAT_W'(1);
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_unified_mem_arbiter.sv
// Randomized bench for unified_mem_arbiter with a transaction-level reference model,
// plus directed reset-abort and continuous-contention phases.
module tb_unified_mem_arbiter;

    localparam int ADDR_W     = 32;
    localparam int DATA_W     = 32;
    localparam int MEM_LAT    = 2;
    localparam int STARVE_MAX = 4;
`ifdef STARVE_GUARD_EN
    localparam bit GUARD = 1'b1;
`else
    localparam bit GUARD = 1'b0;
`endif

    logic              clk = 1'b0;
    logic              n_rst;
    logic              if_req;
    logic [ADDR_W-1:0] if_addr;
    logic              if_gnt;
    logic              if_rvalid;
    logic [DATA_W-1:0] if_rdata;
    logic              d_req;
    logic              d_we;
    logic [ADDR_W-1:0] d_addr;
    logic [DATA_W-1:0] d_wdata;
    logic              d_gnt;
    logic              d_rvalid;
    logic [DATA_W-1:0] d_rdata;
    logic              mem_en;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic [DATA_W-1:0] mem_rdata;
    logic              busy;
    logic [1:0]        dbg_state;

    always #5 clk = ~clk;

    unified_mem_arbiter #(
        .ADDR_W(ADDR_W), .DATA_W(DATA_W), .MEM_LAT(MEM_LAT), .STARVE_MAX(STARVE_MAX)
    ) dut (
        .clk(clk), .n_rst(n_rst),
        .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt),
        .if_rvalid(if_rvalid), .if_rdata(if_rdata),
        .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
        .d_gnt(d_gnt), .d_rvalid(d_rvalid), .d_rdata(d_rdata),
        .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
        .busy(busy), .dbg_state(dbg_state)
    );

    // Memory stand-in: read data is a fixed scramble of the address while enabled.
    function automatic logic [31:0] mem_fn(input logic [31:0] a);
        return {a[15:0], a[31:16]} ^ 32'h1357_9BDF;
    endfunction

    always_comb mem_rdata = mem_en ? mem_fn(mem_addr) : 32'hCAFE_0000;

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check_val(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp)
            n_pass++;
        else
            $display("FAIL %s: got %h expected %h at %0t", tag, act, exp, $time);
    endtask

    // Reference model: an access occupies the memory for MEM_LAT cycles after a grant.
    int          cyc_left = 0;
    int          starve   = 0;
    int          cycle    = 0;
    bit          own_d;
    bit          lat_we;
    logic [31:0] lat_addr;
    logic [31:0] lat_wdata;
    bit          g_if = 1'b0;
    bit          g_d  = 1'b0;
    logic [31:0] exp_if_q[$];
    logic [31:0] exp_d_q[$];

    bit          cap_en = 1'b0;
    logic [9:0]  seq;
    int          n_seq;
    int          gnt_cyc[$];

    always @(negedge clk) begin
        bit d_win;
        bit i_win;
        bit last;
        logic [31:0] e;
        cycle++;
        g_if = 1'b0;
        g_d  = 1'b0;
        if (cap_en && (if_gnt || d_gnt)) begin
            if (n_seq < 10) seq[n_seq] = if_gnt;
            n_seq++;
            gnt_cyc.push_back(cycle);
        end
        if (!n_rst) begin
            check_val("rst_busy", 32'(busy), 0);
            check_val("rst_mem_en", 32'(mem_en), 0);
            check_val("rst_mem_we", 32'(mem_we), 0);
            check_val("rst_gnt", {30'd0, if_gnt, d_gnt}, 0);
            check_val("rst_rvalid", {30'd0, if_rvalid, d_rvalid}, 0);
            cyc_left = 0;
            starve   = 0;
            exp_if_q.delete();
            exp_d_q.delete();
        end else if (cyc_left == 0) begin
            d_win = d_req && !(GUARD && if_req && starve >= STARVE_MAX);
            i_win = if_req && !d_win;
            check_val("idle_busy", 32'(busy), 0);
            check_val("idle_mem_en", 32'(mem_en), 0);
            check_val("d_gnt", 32'(d_gnt), 32'(d_win));
            check_val("if_gnt", 32'(if_gnt), 32'(i_win));
            check_val("idle_rvalid", {30'd0, if_rvalid, d_rvalid}, 0);
            check_val("idle_rdata", if_rdata | d_rdata, 0);
            if (d_win) begin
                starve    = if_req ? ((starve < STARVE_MAX) ? starve + 1 : STARVE_MAX) : 0;
                own_d     = 1'b1;
                lat_addr  = d_addr;
                lat_we    = d_we;
                lat_wdata = d_wdata;
                cyc_left  = MEM_LAT;
                g_d       = 1'b1;
                exp_d_q.push_back(mem_fn(d_addr));
            end else if (i_win) begin
                starve    = 0;
                own_d     = 1'b0;
                lat_addr  = if_addr;
                lat_we    = 1'b0;
                lat_wdata = '0;
                cyc_left  = MEM_LAT;
                g_if      = 1'b1;
                exp_if_q.push_back(mem_fn(if_addr));
            end
        end else begin
            last = (cyc_left == 1);
            check_val("acc_busy", 32'(busy), 1);
            check_val("acc_mem_en", 32'(mem_en), 1);
            check_val("acc_mem_we", 32'(mem_we), 32'(lat_we));
            check_val("acc_mem_addr", mem_addr, lat_addr);
            check_val("acc_mem_wdata", mem_wdata, lat_wdata);
            check_val("acc_no_gnt", {30'd0, if_gnt, d_gnt}, 0);
            check_val("if_rvalid", 32'(if_rvalid), 32'(!own_d && last));
            check_val("d_rvalid", 32'(d_rvalid), 32'(own_d && last));
            if (own_d) check_val("if_rdata_idle", if_rdata, 0);
            else       check_val("d_rdata_idle", d_rdata, 0);
            if (last) begin
                if (own_d) begin
                    e = exp_d_q.pop_front();
                    if (!lat_we) check_val("d_rdata", d_rdata, e);
                end else begin
                    e = exp_if_q.pop_front();
                    check_val("if_rdata", if_rdata, e);
                end
            end
            cyc_left--;
        end
    end

    // Requests are held with stable fields until granted, then re-rolled.
    // mode 0: random mix, 1: both ports always requesting, 2: loads only.
    task automatic drive(input int mode);
        if (!(if_req && !g_if)) begin
            if_req  = (mode == 1) ? 1'b1 : (mode == 2) ? 1'b0 : ($urandom_range(0, 1) == 0);
            if_addr = $urandom() & 32'hFFFF_FFFC;
        end
        if (!(d_req && !g_d)) begin
            d_req   = (mode != 0) ? 1'b1 : ($urandom_range(0, 4) < 2);
            d_we    = (mode == 2) ? 1'b0 : 1'($urandom_range(0, 1));
            d_addr  = $urandom() & 32'hFFFF_FFFC;
            d_wdata = $urandom();
        end
    endtask

    task automatic reset_pulse();
        if_req = 1'b0;
        d_req  = 1'b0;
        n_rst  = 1'b0;
        @(negedge clk);
        #2 n_rst = 1'b1;
    endtask

    initial begin
        bit found;
        n_rst   = 1'b0;
        if_req  = 1'b0;
        if_addr = '0;
        d_req   = 1'b0;
        d_we    = 1'b0;
        d_addr  = '0;
        d_wdata = '0;
        repeat (2) @(negedge clk);
        check_val("rst_mem_addr", mem_addr, 0);
        check_val("rst_mem_wdata", mem_wdata, 0);
        #2 n_rst = 1'b1;

        repeat (300) begin
            @(posedge clk);
            #1 drive(0);
        end

        // Abort an in-flight data access with reset.
        found = 1'b0;
        for (int i = 0; i < 50 && !found; i++) begin
            @(posedge clk);
            #1;
            if (cyc_left > 0 && own_d) found = 1'b1;
            else drive(2);
        end
        check_val("dacc_wait", 32'(found), 1);
        if_req = 1'b0;
        d_req  = 1'b0;
        #2 n_rst = 1'b0;
        #1;
        check_val("abort_busy", 32'(busy), 0);
        check_val("abort_mem_en", 32'(mem_en), 0);
        check_val("abort_d_rvalid", 32'(d_rvalid), 0);
        @(negedge clk);
        #2 n_rst = 1'b1;
        repeat (5) @(posedge clk);

        // Continuous contention from a clean starve count.
        @(posedge clk);
        #1 reset_pulse();
        n_seq = 0;
        seq   = '0;
        gnt_cyc.delete();
        cap_en = 1'b1;
        repeat (40) begin
            @(posedge clk);
            #1 drive(1);
        end
        cap_en = 1'b0;
        check_val("contention_grants", 32'(n_seq >= 10), 1);
        check_val("starve_seq", 32'(seq), GUARD ? 32'h210 : 32'h0);
        for (int i = 1; i < gnt_cyc.size(); i++)
            check_val("gnt_gap", 32'(gnt_cyc[i] - gnt_cyc[i-1]), MEM_LAT + 1);

        repeat (200) begin
            @(posedge clk);
            #1 drive(0);
        end
        if_req = 1'b0;
        d_req  = 1'b0;
        repeat (MEM_LAT + 3) @(posedge clk);
        check_val("drain_if_q", exp_if_q.size(), 0);
        check_val("drain_d_q", exp_d_q.size(), 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
